// File: rtl/muldiv_pkg.sv
// Shared decode constants, FSM state type and helpers
// for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_e;

  function automatic logic is_start(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_MULTU) ||
           (f == FN_DIV)  || (f == FN_DIVU);
  endfunction

  function automatic logic is_hilo(input logic [5:0] f);
    return (f == FN_MFHI) || (f == FN_MTHI) ||
           (f == FN_MFLO) || (f == FN_MTLO);
  endfunction

  function automatic logic is_signed_op(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_DIV);
  endfunction

  function automatic logic is_div_op(input logic [5:0] f);
    return (f == FN_DIV) || (f == FN_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// EX-stage bundle between pipeline and muldiv_unit.
// master drives i_* (pipeline), slave drives o_* (unit).
interface muldiv_if #(
  parameter int DATA_W = 32
);
  logic              i_valid;
  logic              i_flush;
  logic [5:0]        i_opcode;
  logic [5:0]        i_funct;
  logic [DATA_W-1:0] i_rs_data;
  logic [DATA_W-1:0] i_rt_data;
  logic              o_stall;
  logic              o_busy;
  logic [DATA_W-1:0] o_result;
  logic              o_done;
  logic              o_div_by_zero;
  logic [DATA_W-1:0] o_hi;
  logic [DATA_W-1:0] o_lo;

  modport master (
    output i_valid, i_flush, i_opcode, i_funct,
    output i_rs_data, i_rt_data,
    input  o_stall, o_busy, o_result, o_done,
    input  o_div_by_zero, o_hi, o_lo
  );

  modport slave (
    input  i_valid, i_flush, i_opcode, i_funct,
    input  i_rs_data, i_rt_data,
    output o_stall, o_busy, o_result, o_done,
    output o_div_by_zero, o_hi, o_lo
  );
endinterface

// File: rtl/muldiv_core.sv
// One iteration step: shift-add multiply or restoring divide.
// Ports: is_div_i selects step, acc_i/opb_i in, acc_o next acc.
module muldiv_core #(
  parameter int DATA_W = 32
) (
  input  logic                  is_div_i,
  input  logic [2*DATA_W-1:0]   acc_i,
  input  logic [DATA_W-1:0]     opb_i,
  output logic [2*DATA_W-1:0]   acc_o
);

  logic [DATA_W:0] mul_sum;
  logic [DATA_W:0] div_shift;
  logic [DATA_W:0] div_trial;

  // mul: acc = {partial, multiplier}; add on LSB, shift right.
  // div: acc = {remainder, dividend/quotient}; shift left, trial sub.
  always_comb begin
    mul_sum   = {1'b0, acc_i[2*DATA_W-1:DATA_W]}
              + (acc_i[0] ? {1'b0, opb_i} : '0);
    div_shift = acc_i[2*DATA_W-1:DATA_W-1];
    div_trial = div_shift - {1'b0, opb_i};
    acc_o     = {mul_sum, acc_i[DATA_W-1:1]};
    if (is_div_i) begin
      if (!div_trial[DATA_W]) begin
        acc_o = {div_trial[DATA_W-1:0],
                 acc_i[DATA_W-2:0], 1'b1};
      end else begin
        acc_o = {div_shift[DATA_W-1:0],
                 acc_i[DATA_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/DIV unit with private HI/LO, EX-stage side car.
// Ports: i_clk, i_rst (async high), bus (muldiv_if.slave).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic     i_clk,
  input  logic     i_rst,
  muldiv_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_W);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [2*DATA_W-1:0] acc_q;
  logic [2*DATA_W-1:0] acc_step;
  logic [DATA_W-1:0]   opb_q;
  logic [DATA_W-1:0]   hi_q, lo_q;
  logic                div_q, neg_q, neg_rem_q, dz_q;
  logic                done_q, dz_out_q;

  logic                decoded, accept, start, op_signed, op_div;
  logic [DATA_W-1:0]   rs_mag, rt_mag;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix, fix_hi, fix_lo;

  assign decoded = bus.i_valid
                && (bus.i_opcode == OPC_RTYPE)
                && (is_start(bus.i_funct) || is_hilo(bus.i_funct));
  assign accept  = decoded && !bus.i_flush && (state_q == IDLE);
  assign start   = accept && is_start(bus.i_funct);

  assign op_signed = is_signed_op(bus.i_funct);
  assign op_div    = is_div_op(bus.i_funct);

  assign rs_mag = (op_signed && bus.i_rs_data[DATA_W-1])
                ? -bus.i_rs_data : bus.i_rs_data;
  assign rt_mag = (op_signed && bus.i_rt_data[DATA_W-1])
                ? -bus.i_rt_data : bus.i_rt_data;

  muldiv_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .is_div_i (state_q == DIV),
    .acc_i    (acc_q),
    .opb_i    (opb_q),
    .acc_o    (acc_step)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.i_flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (start) state_d = op_div ? DIV : MUL;
        MUL,
        DIV:  if (cnt_q == '0) state_d = FIX;
        FIX:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Sign correction; divide-by-zero forces quotient to all ones,
  // remainder then naturally equals the original dividend.
  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*DATA_W-1:DATA_W]
                         : acc_q[2*DATA_W-1:DATA_W];
    if (div_q) begin
      fix_hi = rem_fix;
      fix_lo = dz_q ? '1 : quo_fix;
    end else begin
      fix_hi = prod_fix[2*DATA_W-1:DATA_W];
      fix_lo = prod_fix[DATA_W-1:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
      dz_out_q  <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      dz_out_q <= 1'b0;
      if (!bus.i_flush) begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              div_q     <= op_div;
              acc_q     <= {{DATA_W{1'b0}},
                            op_div ? rs_mag : rt_mag};
              opb_q     <= op_div ? rt_mag : rs_mag;
              neg_q     <= op_signed && (bus.i_rs_data[DATA_W-1]
                                       ^ bus.i_rt_data[DATA_W-1]);
              neg_rem_q <= op_signed && bus.i_rs_data[DATA_W-1];
              dz_q      <= (bus.i_rt_data == '0);
              cnt_q     <= CNT_W'(DATA_W - 1);
            end
            if (accept && (bus.i_funct == FN_MTHI))
              hi_q <= bus.i_rs_data;
            if (accept && (bus.i_funct == FN_MTLO))
              lo_q <= bus.i_rs_data;
          end
          MUL,
          DIV: begin
            acc_q <= acc_step;
            if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
          end
          FIX: begin
            hi_q     <= fix_hi;
            lo_q     <= fix_lo;
            done_q   <= 1'b1;
            dz_out_q <= div_q && dz_q;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.o_result = '0;
    if (bus.i_valid && (bus.i_opcode == OPC_RTYPE)) begin
      if (bus.i_funct == FN_MFHI) bus.o_result = hi_q;
      if (bus.i_funct == FN_MFLO) bus.o_result = lo_q;
    end
  end

  assign bus.o_stall       = decoded && (state_q != IDLE);
  assign bus.o_busy        = (state_q != IDLE);
  assign bus.o_done        = done_q;
  assign bus.o_div_by_zero = dz_out_q;
  assign bus.o_hi          = hi_q;
  assign bus.o_lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (DATA_W=32 and DATA_W=8).
// Scoreboard of expected HI/LO/div-by-zero popped on o_done.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  exp_t sb[$];
  exp_t sb8[$];

  muldiv_if #(.DATA_W(32)) bus ();
  muldiv_if #(.DATA_W(8))  bus8 ();

  muldiv_unit #(.DATA_W(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  muldiv_unit #(.DATA_W(8)) dut8 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus8)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && bus.o_done) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done32 got done=1 want no done");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({bus.o_hi, bus.o_lo, bus.o_div_by_zero}
            !== {e.hi, e.lo, e.dz}) begin
          miscompares++;
          $display("FAIL result32 got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b",
                   bus.o_hi, bus.o_lo, bus.o_div_by_zero,
                   e.hi, e.lo, e.dz);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus8.o_done) begin
      vectors++;
      if (sb8.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done8 got done=1 want no done");
      end else begin
        exp_t e;
        e = sb8.pop_front();
        if ({bus8.o_hi, bus8.o_lo, bus8.o_div_by_zero}
            !== {e.hi[7:0], e.lo[7:0], e.dz}) begin
          miscompares++;
          $display("FAIL result8 got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b",
                   bus8.o_hi, bus8.o_lo, bus8.o_div_by_zero,
                   e.hi[7:0], e.lo[7:0], e.dz);
        end
      end
    end
  end

  task automatic push(input logic [31:0] h, input logic [31:0] l,
                      input logic d);
    exp_t e;
    e.hi = h; e.lo = l; e.dz = d;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    bus.i_valid   = 1'b0;
    bus.i_flush   = 1'b0;
    bus.i_opcode  = 6'd0;
    bus.i_funct   = 6'd0;
    bus.i_rs_data = '0;
    bus.i_rt_data = '0;
  endtask

  task automatic drive(input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b);
    bus.i_valid   = 1'b1;
    bus.i_opcode  = OPC_RTYPE;
    bus.i_funct   = f;
    bus.i_rs_data = a;
    bus.i_rt_data = b;
  endtask

  // Drives one op in cycle 0, then observes cycles 1..40.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, output int busy_n,
                        output int done_n, output int done_at);
    @(negedge clk);
    drive(f, a, b);
    busy_n = 0; done_n = 0; done_at = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) idle_inputs();
      if (bus.o_busy) busy_n++;
      if (bus.o_done) begin
        done_n++;
        done_at = k;
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    bus8.i_valid = 1'b0; bus8.i_flush = 1'b0;
    bus8.i_opcode = 6'd0; bus8.i_funct = 6'd0;
    bus8.i_rs_data = '0; bus8.i_rt_data = '0;
    rst = 1'b1;
    @(negedge clk);
    drive(FN_MULT, 32'd3, 32'd5);
    @(negedge clk);
    #1;
    vectors++;
    if ({bus.o_busy, bus.o_stall, bus.o_done, bus.o_div_by_zero}
        !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 0000",
               {bus.o_busy, bus.o_stall, bus.o_done,
                bus.o_div_by_zero});
    end
    vectors++;
    if ({bus.o_hi, bus.o_lo} !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_hilo got %h want 0", {bus.o_hi, bus.o_lo});
    end
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    int bn, dn, da;
    push(32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op(FN_MULT, 32'hFFFF_FFFD, 32'd5, bn, dn, da);
    vectors++;
    if (bn !== 33) begin
      miscompares++;
      $display("FAIL mult_busy_cycles got %0d want 33", bn);
    end
    vectors++;
    if (dn !== 1 || da !== 34) begin
      miscompares++;
      $display("FAIL mult_done got count=%0d at=%0d want 1 at 34",
               dn, da);
    end
    push(32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bn, dn, da);
    push(32'h4000_0000, 32'h0000_0000, 1'b0);
    run_op(FN_MULT, 32'h8000_0000, 32'h8000_0000, bn, dn, da);
    push(32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0);
    run_op(FN_MULT, 32'd7, 32'hFFFF_FFFF, bn, dn, da);
  endtask

  task automatic test_div();
    int bn, dn, da;
    push(32'h0000_0002, 32'h0000_000E, 1'b0);
    run_op(FN_DIVU, 32'd100, 32'd7, bn, dn, da);
    vectors++;
    if (bn !== 33 || da !== 34) begin
      miscompares++;
      $display("FAIL divu_timing got busy=%0d done_at=%0d want 33 34",
               bn, da);
    end
    push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op(FN_DIV, 32'hFFFF_FFF9, 32'd2, bn, dn, da);
    push(32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run_op(FN_DIV, 32'd7, 32'hFFFF_FFFE, bn, dn, da);
    push(32'h8000_0000, 32'h0000_0000, 1'b0);
    run_op(FN_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, bn, dn, da);
  endtask

  task automatic test_div_edge();
    int bn, dn, da;
    push(32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
    run_op(FN_DIV, 32'h1234_5678, 32'd0, bn, dn, da);
    vectors++;
    if (bn !== 33 || dn !== 1) begin
      miscompares++;
      $display("FAIL divzero_timing got busy=%0d done=%0d want 33 1",
               bn, dn);
    end
    push(32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);
    run_op(FN_DIV, 32'hFFFF_FFF0, 32'd0, bn, dn, da);
    push(32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, bn, dn, da);
  endtask

  task automatic test_mf_stall();
    int stall_n;
    int done_k;
    stall_n = 0; done_k = -1;
    push(32'd0, 32'd42, 1'b0);
    @(negedge clk);
    drive(FN_MULT, 32'd7, 32'd6);
    @(negedge clk);
    drive(FN_MFLO, 32'd0, 32'd0);
    for (int k = 1; k <= 40; k++) begin
      #1;
      if (bus.o_stall) stall_n++;
      if (bus.o_done) begin
        done_k = k;
        vectors++;
        if (bus.o_result !== 32'd42 || bus.o_stall !== 1'b0) begin
          miscompares++;
          $display("FAIL mf_in_done_cycle got res=%h stall=%b want 0000002a 0",
                   bus.o_result, bus.o_stall);
        end
        break;
      end
      @(negedge clk);
    end
    idle_inputs();
    vectors++;
    if (stall_n !== 33 || done_k !== 34) begin
      miscompares++;
      $display("FAIL mf_stall got stalls=%0d done_at=%0d want 33 34",
               stall_n, done_k);
    end
    @(negedge clk);
  endtask

  task automatic test_mt_mf();
    @(negedge clk);
    drive(FN_MTHI, 32'hAABB_CCDD, 32'd0);
    #1;
    vectors++;
    if (bus.o_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL mthi_stall got %b want 0", bus.o_stall);
    end
    @(negedge clk);
    drive(FN_MFHI, 32'd0, 32'd0);
    #1;
    vectors++;
    if (bus.o_hi !== 32'hAABB_CCDD) begin
      miscompares++;
      $display("FAIL mthi_write got %h want aabbccdd", bus.o_hi);
    end
    vectors++;
    if (bus.o_result !== 32'hAABB_CCDD || bus.o_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL mfhi_read got res=%h stall=%b want aabbccdd 0",
               bus.o_result, bus.o_stall);
    end
    @(negedge clk);
    drive(FN_MTLO, 32'h1122_3344, 32'd0);
    @(negedge clk);
    drive(FN_MFLO, 32'd0, 32'd0);
    #1;
    vectors++;
    if (bus.o_result !== 32'h1122_3344) begin
      miscompares++;
      $display("FAIL mflo_read got %h want 11223344", bus.o_result);
    end
    bus.i_opcode = 6'd1;
    bus.i_funct  = FN_MFHI;
    #1;
    vectors++;
    if (bus.o_result !== 32'd0) begin
      miscompares++;
      $display("FAIL bad_opcode got %h want 0", bus.o_result);
    end
    bus.i_opcode = OPC_RTYPE;
    bus.i_valid  = 1'b0;
    #1;
    vectors++;
    if (bus.o_result !== 32'd0) begin
      miscompares++;
      $display("FAIL invalid_mf got %h want 0", bus.o_result);
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    int dn;
    logic busy10;
    dn = 0; busy10 = 1'b0;
    @(negedge clk);
    drive(FN_DIV, 32'd1000, 32'd3);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) idle_inputs();
    end
    busy10 = bus.o_busy;
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    vectors++;
    if (busy10 !== 1'b1 || bus.o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_idle got busy_before=%b busy_after=%b want 1 0",
               busy10, bus.o_busy);
    end
    for (int k = 0; k < 40; k++) begin
      if (bus.o_done) dn++;
      @(negedge clk);
    end
    vectors++;
    if (dn !== 0) begin
      miscompares++;
      $display("FAIL flush_no_done got %0d want 0", dn);
    end
    vectors++;
    if ({bus.o_hi, bus.o_lo} !== {32'hAABB_CCDD, 32'h1122_3344}) begin
      miscompares++;
      $display("FAIL flush_hilo got %h want aabbccdd11223344",
               {bus.o_hi, bus.o_lo});
    end
  endtask

  task automatic test_reset_mid();
    int dn;
    dn = 0;
    @(negedge clk);
    drive(FN_DIV, 32'd1000, 32'd3);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) idle_inputs();
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.o_busy, bus.o_stall} !== 2'b00 ||
        {bus.o_hi, bus.o_lo} !== 64'd0) begin
      miscompares++;
      $display("FAIL async_reset got busy=%b stall=%b hilo=%h want 0 0 0",
               bus.o_busy, bus.o_stall, {bus.o_hi, bus.o_lo});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.o_done) dn++;
    end
    vectors++;
    if (dn !== 0 || bus.o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_no_done got done=%0d busy=%b want 0 0",
               dn, bus.o_busy);
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    t1 = -1; t2 = -1;
    push(32'd0, 32'd6, 1'b0);
    push(32'd1, 32'hFFFF_FFFE, 1'b0);
    @(negedge clk);
    drive(FN_MULT, 32'd2, 32'd3);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) drive(FN_MULTU, 32'hFFFF_FFFF, 32'd2);
      if (t1 >= 0 && k == t1 + 1) idle_inputs();
      if (bus.o_done) begin
        if (t1 < 0) t1 = k;
        else begin
          t2 = k;
          break;
        end
      end
    end
    idle_inputs();
    vectors++;
    if (t1 !== 34 || (t2 - t1) !== 34) begin
      miscompares++;
      $display("FAIL back_to_back got first=%0d gap=%0d want 34 34",
               t1, t2 - t1);
    end
    @(negedge clk);
  endtask

  task automatic test_w8();
    int bn, da;
    exp_t e;
    bn = 0; da = -1;
    e.hi = 32'h00; e.lo = 32'h0C; e.dz = 1'b0;
    sb8.push_back(e);
    @(negedge clk);
    bus8.i_valid = 1'b1; bus8.i_opcode = OPC_RTYPE;
    bus8.i_funct = FN_MULT;
    bus8.i_rs_data = 8'd3; bus8.i_rt_data = 8'd4;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) bus8.i_valid = 1'b0;
      if (bus8.o_busy) bn++;
      if (bus8.o_done) da = k;
    end
    vectors++;
    if (bn !== 9 || da !== 10) begin
      miscompares++;
      $display("FAIL w8_timing got busy=%0d done_at=%0d want 9 10",
               bn, da);
    end
    e.hi = 32'hFF; e.lo = 32'hFD; e.dz = 1'b0;
    sb8.push_back(e);
    @(negedge clk);
    bus8.i_valid = 1'b1; bus8.i_funct = FN_DIV;
    bus8.i_rs_data = 8'hF9; bus8.i_rt_data = 8'd2;
    @(negedge clk);
    bus8.i_valid = 1'b0;
    repeat (15) @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_mult();
    test_div();
    test_div_edge();
    test_mf_stall();
    test_mt_mf();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_w8();
    repeat (3) @(negedge clk);
    vectors++;
    if (sb.size() !== 0 || sb8.size() !== 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d/%0d pending want 0/0",
               sb.size(), sb8.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
